// File: rtl/ram_s4_arbiter.sv
// rtl/ram_s4_arbiter.sv - round-robin two-requester arbiter and clear sequencer for a 4K x 4 single-port RAM
module ram_s4_arbiter #(
    parameter int                 ADDR_W  = 12,
    parameter int                 DATA_W  = 4,
    parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
    input  logic              CLK,
    input  logic              RST,

    input  logic              A_REQ,
    input  logic              A_WE,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic [DATA_W-1:0] A_DI,
    output logic              A_GNT,
    output logic              A_VLD,
    output logic [DATA_W-1:0] A_DO,

    input  logic              B_REQ,
    input  logic              B_WE,
    input  logic [ADDR_W-1:0] B_ADDR,
    input  logic [DATA_W-1:0] B_DI,
    output logic              B_GNT,
    output logic              B_VLD,
    output logic [DATA_W-1:0] B_DO,

    input  logic              CLR_START,
    output logic              CLR_BUSY,
    output logic              CLR_DONE,

    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [DATA_W-1:0] RAM_DI,
    output logic              RAM_EN,
    output logic              RAM_WE,
    output logic              RAM_SSR,
    input  logic [DATA_W-1:0] RAM_DO
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t            state;
    logic              ptr;        // 0: A wins a tie, 1: B wins a tie
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] di_q;
    logic              a_own;
    logic              b_own;
    logic              busy_q;
    logic              done_q;

    logic              arb_ok;
    logic              clr_act;
    logic              gnt_a;
    logic              gnt_b;
    logic              last_cnt;

    always_comb begin
        arb_ok   = !RST && (state == S_IDLE);
        clr_act  = !RST && (state == S_CLEAR);
        gnt_a    = arb_ok && A_REQ && (!B_REQ || !ptr);
        gnt_b    = arb_ok && B_REQ && (!A_REQ ||  ptr);
        last_cnt = (clr_cnt == {ADDR_W{1'b1}});
    end

    // Idle cycles replay the last address/data so the RAM pins stay quiet.
    always_comb begin
        RAM_EN   = 1'b0;
        RAM_WE   = 1'b0;
        RAM_ADDR = addr_q;
        RAM_DI   = di_q;
        if (clr_act) begin
            RAM_EN   = 1'b1;
            RAM_WE   = 1'b1;
            RAM_ADDR = clr_cnt;
            RAM_DI   = CLR_VAL;
        end else if (gnt_a) begin
            RAM_EN   = 1'b1;
            RAM_WE   = A_WE;
            RAM_ADDR = A_ADDR;
            RAM_DI   = A_DI;
        end else if (gnt_b) begin
            RAM_EN   = 1'b1;
            RAM_WE   = B_WE;
            RAM_ADDR = B_ADDR;
            RAM_DI   = B_DI;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            ptr     <= 1'b0;
            clr_cnt <= '0;
            addr_q  <= '0;
            di_q    <= '0;
            a_own   <= 1'b0;
            b_own   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            addr_q <= RAM_ADDR;
            di_q   <= RAM_DI;
            // Only reads claim the next-cycle RAM_DO; write-through data is dropped.
            a_own  <= gnt_a && !A_WE;
            b_own  <= gnt_b && !B_WE;
            done_q <= 1'b0;

            if (gnt_a) begin
                ptr <= 1'b1;
            end else if (gnt_b) begin
                ptr <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (CLR_START) begin
                        state   <= S_CLEAR;
                        busy_q  <= 1'b1;
                        clr_cnt <= '0;
                    end
                end
                S_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (last_cnt) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign A_GNT    = gnt_a;
    assign B_GNT    = gnt_b;
    assign A_VLD    = a_own;
    assign B_VLD    = b_own;
    assign A_DO     = RAM_DO;
    assign B_DO     = RAM_DO;
    assign CLR_BUSY = busy_q;
    assign CLR_DONE = done_q;
    assign RAM_SSR  = 1'b0;

endmodule

// File: tb/tb_ram_s4_arbiter.sv
// tb/tb_ram_s4_arbiter.sv - directed self-checking bench for ram_s4_arbiter with a behavioural RAM
module tb_ram_s4_arbiter;

    logic        clk;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [11:0] a_addr, b_addr;
    logic [3:0]  a_di, b_di;
    logic        a_gnt, a_vld, b_gnt, b_vld;
    logic [3:0]  a_do, b_do;
    logic        clr_start, clr_busy, clr_done;
    logic [11:0] ram_addr;
    logic [3:0]  ram_di, ram_do;
    logic        ram_en, ram_we, ram_ssr;

    int n_chk  = 0;
    int n_pass = 0;

    logic [3:0] mem [0:4095];

    ram_s4_arbiter #(.ADDR_W(12), .DATA_W(4), .CLR_VAL(4'h0)) dut (
        .CLK(clk), .RST(rst),
        .A_REQ(a_req), .A_WE(a_we), .A_ADDR(a_addr), .A_DI(a_di),
        .A_GNT(a_gnt), .A_VLD(a_vld), .A_DO(a_do),
        .B_REQ(b_req), .B_WE(b_we), .B_ADDR(b_addr), .B_DI(b_di),
        .B_GNT(b_gnt), .B_VLD(b_vld), .B_DO(b_do),
        .CLR_START(clr_start), .CLR_BUSY(clr_busy), .CLR_DONE(clr_done),
        .RAM_ADDR(ram_addr), .RAM_DI(ram_di), .RAM_EN(ram_en),
        .RAM_WE(ram_we), .RAM_SSR(ram_ssr), .RAM_DO(ram_do)
    );

    // Write-first synchronous single-port RAM.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_di;
                ram_do        <= ram_di;
            end else begin
                ram_do <= mem[ram_addr];
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic a_write(input logic [11:0] addr, input logic [3:0] di);
        a_req = 1'b1; a_we = 1'b1; a_addr = addr; a_di = di;
        #1;
        check("a_wr_gnt", a_gnt, 1);
        check("a_wr_ram_we", ram_we, 1);
        tick();
        a_req = 1'b0;
        check("a_wr_no_vld", a_vld, 0);
    endtask

    task automatic a_read(input logic [11:0] addr, input logic [3:0] exp);
        a_req = 1'b1; a_we = 1'b0; a_addr = addr;
        #1;
        check("a_rd_gnt", a_gnt, 1);
        tick();
        a_req = 1'b0;
        check("a_rd_vld", a_vld, 1);
        check("a_rd_do", a_do, exp);
        check("a_rd_b_vld", b_vld, 0);
    endtask

    initial begin
        for (int k = 0; k < 4096; k++) mem[k] = 4'h3;
        rst = 1'b1; clr_start = 1'b0;
        a_req = 1'b1; a_we = 1'b1; a_addr = 12'h000; a_di = 4'h0;
        b_req = 1'b1; b_we = 1'b1; b_addr = 12'h000; b_di = 4'h0;
        tick();
        #1;
        check("rst_a_gnt", a_gnt, 0);
        check("rst_b_gnt", b_gnt, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_we", ram_we, 0);
        tick();
        rst = 1'b0; a_req = 1'b0; b_req = 1'b0;
        check("rst_a_vld", a_vld, 0);
        check("rst_b_vld", b_vld, 0);
        check("rst_busy", clr_busy, 0);
        check("rst_done", clr_done, 0);
        check("rst_ssr", ram_ssr, 0);

        // Single requester write then read-back.
        a_req = 1'b1; a_we = 1'b1; a_addr = 12'h005; a_di = 4'hA;
        #1;
        check("t1_gnt", a_gnt, 1);
        check("t1_en", ram_en, 1);
        check("t1_addr", ram_addr, 12'h005);
        check("t1_di", ram_di, 4'hA);
        check("t1_we", ram_we, 1);
        tick();
        check("t1_wr_no_vld", a_vld, 0);
        check("t1_b_vld0", b_vld, 0);
        a_we = 1'b0;
        #1;
        check("t1_rd_gnt", a_gnt, 1);
        check("t1_rd_we", ram_we, 0);
        tick();
        a_req = 1'b0;
        check("t1_rd_vld", a_vld, 1);
        check("t1_rd_do", a_do, 4'hA);
        check("t1_b_vld1", b_vld, 0);
        #1;
        check("t1_idle_en", ram_en, 0);
        check("t1_idle_we", ram_we, 0);
        check("t1_idle_addr_hold", ram_addr, 12'h005);
        tick();
        check("t1_idle_vld", a_vld, 0);

        // Fresh pointer, B preloads 0x00A with 4'h6.
        rst = 1'b1; tick(); rst = 1'b0;
        b_req = 1'b1; b_we = 1'b1; b_addr = 12'h00A; b_di = 4'h6;
        #1;
        check("t2_b_wr_gnt", b_gnt, 1);
        tick();
        b_req = 1'b0;
        // Pointer now A; contested reads must alternate A,B,A,B.
        rst = 1'b1; tick(); rst = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 12'h005;
        b_req = 1'b1; b_we = 1'b0; b_addr = 12'h00A;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t2_a_gnt", a_gnt, (i % 2 == 0));
            check("t2_b_gnt", b_gnt, (i % 2 == 1));
            tick();
            check("t2_a_vld", a_vld, (i % 2 == 0));
            check("t2_b_vld", b_vld, (i % 2 == 1));
            check("t2_do", (i % 2 == 0) ? a_do : b_do, (i % 2 == 0) ? 4'hA : 4'h6);
        end

        // B alone three times, then contention starts with A.
        a_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_b_alone_gnt", b_gnt, 1);
            check("t3_a_alone_gnt", a_gnt, 0);
            tick();
            check("t3_b_vld", b_vld, 1);
        end
        a_req = 1'b1;
        #1;
        check("t3_c1_a_gnt", a_gnt, 1);
        check("t3_c1_b_gnt", b_gnt, 0);
        tick();
        #1;
        check("t3_c2_a_gnt", a_gnt, 0);
        check("t3_c2_b_gnt", b_gnt, 1);
        tick();
        a_req = 1'b0; b_req = 1'b0;

        // Full clear sweep with a pending request and an ignored mid-sweep start.
        a_write(12'h000, 4'hF);
        a_write(12'hFFF, 4'hF);
        clr_start = 1'b1;
        #1;
        check("t4_start_no_en", ram_en, 0);
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            if (i == 10) begin
                a_req = 1'b1; a_we = 1'b0; a_addr = 12'h000;
            end
            clr_start = (i == 2000);
            #1;
            check("t4_addr", ram_addr, i);
            if (i == 0 || i == 2000 || i == 4095) begin
                check("t4_busy", clr_busy, 1);
                check("t4_en", ram_en, 1);
                check("t4_we", ram_we, 1);
                check("t4_di", ram_di, 4'h0);
                check("t4_done0", clr_done, 0);
            end
            if (i >= 10) check("t4_no_gnt", a_gnt, 0);
            tick();
        end
        clr_start = 1'b0;
        #1;
        check("t4_done", clr_done, 1);
        check("t4_busy_off", clr_busy, 0);
        check("t4_gnt_on_done", a_gnt, 1);
        check("t4_gnt_addr", ram_addr, 12'h000);
        tick();
        a_req = 1'b0;
        check("t4_rd0_vld", a_vld, 1);
        check("t4_rd0_do", a_do, 4'h0);
        check("t4_done_pulse", clr_done, 0);
        a_read(12'hFFF, 4'h0);

        // Reset at sweep cycle 100 aborts without CLR_DONE.
        a_write(12'h0FF, 4'h7);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        rst = 1'b1;
        #1;
        check("t5_rst_en", ram_en, 0);
        tick();
        rst = 1'b0;
        check("t5_busy", clr_busy, 0);
        check("t5_done", clr_done, 0);
        a_req = 1'b1; a_we = 1'b0; a_addr = 12'h0FF;
        b_req = 1'b1; b_we = 1'b0; b_addr = 12'h000;
        #1;
        check("t5_ptr_a_gnt", a_gnt, 1);
        check("t5_ptr_b_gnt", b_gnt, 0);
        tick();
        a_req = 1'b0;
        check("t5_a_vld", a_vld, 1);
        check("t5_a_do", a_do, 4'h7);
        check("t5_done_after", clr_done, 0);
        #1;
        check("t5_b_gnt", b_gnt, 1);
        tick();
        b_req = 1'b0;
        check("t5_b_vld", b_vld, 1);
        check("t5_b_do", b_do, 4'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_no_done", clr_done, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
